serial_subtractor: RTL

Bit-serial, LSB-first N-bit subtractor computing `a - b` one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the sequential counterpart to the team's combinational half-adder cells, and the building block for area-constrained arithmetic datapaths in the lab designs. It uses a start/busy/done handshake so a testbench or controller can drive operands and collect results.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = (a - b) mod 2^WIDTH using one full-subtractor cell.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             br_next_s;

  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // Next-state logic; the DONE exit edge doubles as an accept point so that
  // back-to-back operations run every WIDTH+1 cycles.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    last_s    = (cnt_r == CW'(WIDTH - 1));
    d_s       = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
    br_next_s = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, operand shifters, borrow FF and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      br_r    <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_r == RUN) && last_s;
      if (accept_s) begin
        a_sh_r <= a;
        b_sh_r <= b;
        br_r   <= 1'b0;
        cnt_r  <= '0;
        diff   <= '0;
        b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= 1'b0;
`endif
      end else if (state_r == RUN) begin
        a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
        br_r   <= br_next_s;
        cnt_r  <= cnt_r + CW'(1);
        diff   <= {d_s, diff[WIDTH-1:1]};
        if (last_s) begin
          b_out <= br_next_s;
`ifdef SERIAL_SUB_OVF_EN
          // At the last edge the shifter LSBs hold the original operand MSBs.
          ovf   <= (a_sh_r[0] ^ b_sh_r[0]) & (a_sh_r[0] ^ d_s);
`endif
        end
      end
    end
  end

endmodule
